// File: rtl/mem_datapath_pkg.sv
// Shared constants and strobe bundle for the memory datapath and its control decoders.
package mem_datapath_pkg;

   localparam int DEF_DATA_W  = 8;
   localparam int DEF_A_DEPTH = 8;
   localparam int DEF_B_DEPTH = 4;

   // Address width for a given depth; a depth of 1 still needs a 1-bit bus.
   function automatic int addr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   localparam int DEF_A_AW = addr_w(DEF_A_DEPTH);
   localparam int DEF_B_AW = addr_w(DEF_B_DEPTH);

   typedef struct packed {
      logic clr;
      logic wea;
      logic inca;
      logic web;
      logic incb;
   } ctl_t;

endpackage

// File: rtl/mem_datapath_addr_cnt.sv
// Modulo-DEPTH address counter with synchronous clear and asynchronous reset.
module addr_cnt #(
   parameter int W     = 3,
   parameter int DEPTH = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] cnt
);

   localparam logic [W-1:0] LAST = W'(DEPTH - 1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt <= '0;
      else if (clr)
         cnt <= '0;
      else if (inc)
         cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
   end

endmodule

// File: rtl/mem_datapath.sv
// Pairwise-sum datapath: words written into memory A are read through a two-stage
// pipeline, adjacent pairs summed with carry, and the sums stored into memory B.
module mem_datapath
   import mem_datapath_pkg::*;
#(
   parameter int DATA_W  = DEF_DATA_W,
   parameter int A_DEPTH = DEF_A_DEPTH,
   parameter int B_DEPTH = DEF_B_DEPTH
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        clr,
   input  logic                        wea,
   input  logic                        inca,
   input  logic                        web,
   input  logic                        incb,
   input  logic [DATA_W-1:0]           data_in,
   input  logic [addr_w(B_DEPTH)-1:0]  rd_addr_b,
   output logic [DATA_W:0]             dout_b,
   output logic [addr_w(A_DEPTH)-1:0]  addr_a,
   output logic [addr_w(B_DEPTH)-1:0]  addr_b,
   output logic                        done
);

   localparam int A_AW = addr_w(A_DEPTH);
   localparam int B_AW = addr_w(B_DEPTH);
   localparam logic [B_AW-1:0] B_LAST = B_AW'(B_DEPTH - 1);

   ctl_t ctl;
   assign ctl = '{clr: clr, wea: wea, inca: inca, web: web, incb: incb};

   // clr outranks every strobe, so writes are gated here once for all users
   logic wr_a, wr_b, adv_a;
   assign wr_a  = ctl.wea  & ~ctl.clr;
   assign wr_b  = ctl.web  & ~ctl.clr;
   assign adv_a = ctl.inca & ~ctl.clr;

   logic [DATA_W-1:0] mem_a [A_DEPTH];
   logic [DATA_W:0]   mem_b [B_DEPTH];
   logic [DATA_W-1:0] rd_a;
   logic [DATA_W-1:0] q1, q2;
   logic [DATA_W:0]   sum;

   addr_cnt #(.W(A_AW), .DEPTH(A_DEPTH)) u_addr_a (
      .clk (clk),
      .rst (rst),
      .clr (ctl.clr),
      .inc (ctl.inca),
      .cnt (addr_a)
   );

   addr_cnt #(.W(B_AW), .DEPTH(B_DEPTH)) u_addr_b (
      .clk (clk),
      .rst (rst),
      .clr (ctl.clr),
      .inc (ctl.incb),
      .cnt (addr_b)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < A_DEPTH; i++)
            mem_a[i] <= '0;
      end else if (wr_a) begin
         mem_a[addr_a] <= data_in;
      end
   end

   // Combinational read sees the pre-edge word, so a same-cycle write is not forwarded
   assign rd_a = mem_a[addr_a];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q1 <= '0;
         q2 <= '0;
      end else if (ctl.clr) begin
         q1 <= '0;
         q2 <= '0;
      end else if (adv_a) begin
         q1 <= rd_a;
         q2 <= q1;
      end
   end

   assign sum = {1'b0, q1} + {1'b0, q2};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < B_DEPTH; i++)
            mem_b[i] <= '0;
      end else if (wr_b) begin
         mem_b[addr_b] <= sum;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         dout_b <= '0;
      else
         dout_b <= mem_b[rd_addr_b];
   end

   // Writing the last B word wins over a same-edge A write that would re-arm
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         done <= 1'b0;
      else if (wr_b && addr_b == B_LAST)
         done <= 1'b1;
      else if (wr_a)
         done <= 1'b0;
   end

endmodule

// File: tb/tb_mem_datapath.sv
// Scoreboard bench for mem_datapath: directed frames plus random strobes against an array model.
module tb_mem_datapath;
   import mem_datapath_pkg::*;

   localparam int DW = DEF_DATA_W;

   logic                clk = 1'b0;
   logic                rst, clr, wea, inca, web, incb;
   logic [DW-1:0]       data_in;
   logic [DEF_B_AW-1:0] rd_addr_b;
   logic [DW:0]         dout_b;
   logic [DEF_A_AW-1:0] addr_a;
   logic [DEF_B_AW-1:0] addr_b;
   logic                done;

   mem_datapath dut (
      .clk(clk), .rst(rst), .clr(clr), .wea(wea), .inca(inca), .web(web), .incb(incb),
      .data_in(data_in), .rd_addr_b(rd_addr_b), .dout_b(dout_b),
      .addr_a(addr_a), .addr_b(addr_b), .done(done)
   );

   always #5 clk = ~clk;

   typedef struct {
      int dout;
      int aa;
      int ab;
      int dn;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   checks = 0;
   int   failures = 0;

   // Reference model: plain arrays and integers
   int ma[DEF_A_DEPTH];
   int mb[DEF_B_DEPTH];
   int maa, mab, mq1, mq2, mdone, mdout;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   task automatic model_reset();
      foreach (ma[i]) ma[i] = 0;
      foreach (mb[i]) mb[i] = 0;
      maa = 0; mab = 0; mq1 = 0; mq2 = 0; mdone = 0; mdout = 0;
   endtask

   task automatic model_step();
      int s, rda;
      mdout = mb[rd_addr_b];
      if (clr) begin
         maa = 0; mab = 0; mq1 = 0; mq2 = 0;
      end else begin
         s   = mq1 + mq2;
         rda = ma[maa];
         if (web && mab == DEF_B_DEPTH - 1) mdone = 1;
         else if (wea)                      mdone = 0;
         if (wea) ma[maa] = data_in;
         if (web) mb[mab] = s;
         if (inca) begin
            mq2 = mq1;
            mq1 = rda;
            maa = (maa + 1) % DEF_A_DEPTH;
         end
         if (incb) mab = (mab + 1) % DEF_B_DEPTH;
      end
   endtask

   // Drive one cycle, update model at the edge, queue the expected outputs
   task automatic cyc(input bit c, input bit wa, input bit ia, input bit wb, input bit ib,
                      input int din = 0, input int rd = 0);
      exp_t e;
      clr = c; wea = wa; inca = ia; web = wb; incb = ib;
      data_in = din[DW-1:0];
      rd_addr_b = rd[DEF_B_AW-1:0];
      @(posedge clk);
      model_step();
      e.dout = mdout; e.aa = maa; e.ab = mab; e.dn = mdone;
      exp_q.push_back(e);
      #1;
   endtask

   task automatic idle_inputs();
      clr = 0; wea = 0; inca = 0; web = 0; incb = 0; data_in = '0; rd_addr_b = '0;
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         chk("mon_dout_b", int'(dout_b), mon_e.dout);
         chk("mon_addr_a", int'(addr_a), mon_e.aa);
         chk("mon_addr_b", int'(addr_b), mon_e.ab);
         chk("mon_done",   int'(done),   mon_e.dn);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   int frame_exp[4] = '{30, 70, 110, 150};

   initial begin
      idle_inputs();
      rst = 1'b1;
      model_reset();
      #1;
      chk("reset_addr_a", int'(addr_a), 0);
      chk("reset_addr_b", int'(addr_b), 0);
      chk("reset_done",   int'(done),   0);
      chk("reset_dout_b", int'(dout_b), 0);
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;

      // Nominal controller frame
      cyc(1, 0, 0, 0, 0);
      for (int k = 1; k <= 18; k++) begin
         cyc(k == 18, k <= 8, k <= 16, k inside {11, 13, 15, 17}, k inside {12, 14, 16, 18},
             (k <= 8) ? 10 * k : 0);
         if (k == 17) chk("done_after_17", int'(done), 1);
      end
      chk("done_after_clr", int'(done), 1);
      for (int k = 0; k < 4; k++) begin
         cyc(0, 0, 0, 0, 0, 0, k);
         chk($sformatf("frame_mem_b%0d", k), int'(dout_b), frame_exp[k]);
      end

      // Carry into the sum MSB
      cyc(1, 0, 0, 0, 0);
      cyc(0, 1, 1, 0, 0, 200);
      cyc(0, 1, 1, 0, 0, 100);
      for (int k = 0; k < 8; k++) cyc(0, 0, 1, 0, 0);
      cyc(0, 0, 0, 1, 0);
      cyc(0, 0, 0, 0, 0, 0, 0);
      chk("carry_mem_b0", int'(dout_b), 'h12C);

      // Address wrap
      cyc(1, 0, 0, 0, 0);
      for (int k = 0; k < 9; k++) cyc(0, 0, 1, 0, 0);
      chk("wrap_addr_a", int'(addr_a), 1);
      for (int k = 0; k < 5; k++) cyc(0, 0, 0, 0, 1);
      chk("wrap_addr_b", int'(addr_b), 1);

      // Write and read of the same A word in one cycle
      cyc(1, 0, 0, 0, 0);
      for (int k = 0; k < 3; k++) cyc(0, 0, 1, 0, 0);
      cyc(0, 1, 0, 0, 0, 7);
      cyc(0, 1, 1, 0, 0, 9);
      chk("collide_q1",     int'(dut.q1),       7);
      chk("collide_mem_a3", int'(dut.mem_a[3]), 9);
      chk("collide_addr_a", int'(addr_a),       4);

      // clr suppresses a write to B
      cyc(1, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 1);
      cyc(1, 0, 0, 1, 0);
      chk("clrweb_addr_b", int'(addr_b), 0);
      chk("clrweb_done",   int'(done),   mdone);
      cyc(0, 0, 0, 0, 0, 0, 2);
      chk("clrweb_mem_b2", int'(dout_b), 110);

      // Asynchronous reset mid-run
      cyc(1, 0, 0, 0, 0);
      for (int k = 0; k < 5; k++) cyc(0, 0, 1, 0, 0);
      chk("pre_reset_addr_a", int'(addr_a), 5);
      idle_inputs();
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("async_addr_a", int'(addr_a), 0);
      chk("async_done",   int'(done),   0);
      chk("async_dout_b", int'(dout_b), 0);
      model_reset();
      @(posedge clk);
      #1 rst = 1'b0;

      // Random strobes
      for (int n = 0; n < 400; n++) begin
         cyc($urandom_range(0, 19) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
             $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
             int'($urandom_range(0, 255)), int'($urandom_range(0, DEF_B_DEPTH - 1)));
      end

      idle_inputs();
      @(negedge clk);
      #1;
      chk("queue_drained", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
